// File: rtl/video_pkg.sv
// Shared definitions for the video test-pattern sources: pattern indices,
// colour-bar palette and the 8-bit to CW channel alignment helper.
package video_pkg;

  localparam int unsigned PAT_W = 4;

  localparam logic [PAT_W-1:0] PAT_BLACK   = 4'd0;
  localparam logic [PAT_W-1:0] PAT_WHITE   = 4'd1;
  localparam logic [PAT_W-1:0] PAT_RED     = 4'd2;
  localparam logic [PAT_W-1:0] PAT_GREEN   = 4'd3;
  localparam logic [PAT_W-1:0] PAT_BLUE    = 4'd4;
  localparam logic [PAT_W-1:0] PAT_CHECK16 = 4'd5;
  localparam logic [PAT_W-1:0] PAT_CHECK64 = 4'd6;
  localparam logic [PAT_W-1:0] PAT_GREY    = 4'd7;
  localparam logic [PAT_W-1:0] PAT_GRAD    = 4'd8;
  localparam logic [PAT_W-1:0] PAT_RRAMP   = 4'd9;
  localparam logic [PAT_W-1:0] PAT_GRAMP   = 4'd10;
  localparam logic [PAT_W-1:0] PAT_BRAMP   = 4'd11;
  localparam logic [PAT_W-1:0] PAT_BARS    = 4'd12;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  // One pixel at 8 bits per channel, before alignment to CW.
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb8_t;

  // Colour-bar palette, left to right.
  function automatic rgb8_t bar_rgb(input logic [2:0] idx);
    rgb8_t c;
    case (idx)
      3'd0:    c = rgb8_t'(BAR_WHITE);
      3'd1:    c = rgb8_t'(BAR_YELLOW);
      3'd2:    c = rgb8_t'(BAR_CYAN);
      3'd3:    c = rgb8_t'(BAR_GREEN);
      3'd4:    c = rgb8_t'(BAR_MAGENTA);
      3'd5:    c = rgb8_t'(BAR_RED);
      3'd6:    c = rgb8_t'(BAR_BLUE);
      default: c = rgb8_t'(BAR_BLACK);
    endcase
    return c;
  endfunction

  // MSB-align an 8-bit value to cw bits; full scale maps to all-ones.
  function automatic logic [31:0] align8(input logic [7:0] val, input int unsigned cw);
    logic [31:0] res;
    if (val == 8'hFF) begin
      res = (cw >= 32) ? '1 : ((32'd1 << cw) - 32'd1);
    end else if (cw >= 8) begin
      res = 32'(val) << (cw - 8);
    end else begin
      res = 32'(val) >> (8 - cw);
    end
    return res;
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Raster timing: h/v counters plus combinational active/sync/wrap flags.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CNT_W    = 12
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] h,
  output logic [CNT_W-1:0] v,
  output logic             de_c,
  output logic             hs_c,
  output logic             vs_c,
  output logic             line_end_c,
  output logic             frame_wrap_c,
  output logic             sof_c
);

  localparam int unsigned HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(HT - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(VT - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEGIN = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEGIN = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  // Pixel and line counters; v advances on the last pixel of each line.
  always_ff @(posedge clk) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (line_end_c) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + CNT_W'(1);
    end else begin
      h <= h + CNT_W'(1);
    end
  end

  // Region and strobe decode from the current counter values.
  always_comb begin
    line_end_c   = (h == H_LAST);
    frame_wrap_c = (h == H_LAST) && (v == V_LAST);
    sof_c        = (h == '0) && (v == '0);
    de_c         = (h < H_ACT) && (v < V_ACT);
    hs_c         = (h >= HS_BEGIN) && (h < HS_END);
    vs_c         = (v >= VS_BEGIN) && (v < VS_END);
  end

endmodule

// File: rtl/video_pattern_gen.sv
// Test-pattern source: frame-synchronous mode selection, pattern mux and a
// single output register stage aligning colour, enables and syncs.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned CW          = 8,
  parameter int unsigned CNT_W       = 12,
  parameter bit          HS_POL      = 1'b0,
  parameter bit          VS_POL      = 1'b0,
  parameter int unsigned AUTO_FRAMES = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       mode_sel,
  input  logic             auto_en,
  output logic [CW-1:0]    r,
  output logic [CW-1:0]    g,
  output logic [CW-1:0]    b,
  output logic             de,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_start,
  output logic [3:0]       mode_cur
);

  localparam int unsigned BW    = H_ACTIVE / 8;
  localparam int unsigned FC_W  = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [CNT_W-1:0] BW_LAST = CNT_W'(BW - 1);
  localparam logic [FC_W-1:0]  FC_LAST = FC_W'(AUTO_FRAMES - 1);

  logic [CNT_W-1:0] h;
  logic [CNT_W-1:0] v;
  logic             de_c;
  logic             hs_c;
  logic             vs_c;
  logic             line_end_c;
  logic             frame_wrap_c;
  logic             sof_c;

  logic [FC_W-1:0]  frame_cnt;
  logic [CNT_W-1:0] bar_pix;
  logic [2:0]       bar_idx;
  rgb8_t            pix_c;
  logic [15:0]      h_ext;
  logic [15:0]      v_ext;
  logic             unused_bits;

  video_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .CNT_W    (CNT_W)
  ) u_timing (
    .clk          (clk),
    .rst          (rst),
    .h            (h),
    .v            (v),
    .de_c         (de_c),
    .hs_c         (hs_c),
    .vs_c         (vs_c),
    .line_end_c   (line_end_c),
    .frame_wrap_c (frame_wrap_c),
    .sof_c        (sof_c)
  );

  // Pattern changes only at the frame wrap; auto mode steps every AUTO_FRAMES.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_cur  <= PAT_BLACK;
      frame_cnt <= '0;
    end else if (!auto_en) begin
      frame_cnt <= '0;
      if (frame_wrap_c) begin
        mode_cur <= mode_sel;
      end
    end else if (frame_wrap_c) begin
      if (frame_cnt == FC_LAST) begin
        frame_cnt <= '0;
        mode_cur  <= (mode_cur >= PAT_BARS) ? PAT_BLACK : mode_cur + 4'd1;
      end else begin
        frame_cnt <= frame_cnt + FC_W'(1);
      end
    end
  end

  // Bar index tracks h with a width counter; saturates at the last bar.
  always_ff @(posedge clk) begin
    if (rst || line_end_c) begin
      bar_pix <= '0;
      bar_idx <= '0;
    end else if (bar_idx != 3'd7) begin
      if (bar_pix == BW_LAST) begin
        bar_pix <= '0;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_pix <= bar_pix + CNT_W'(1);
      end
    end
  end

  // Pattern mux at 8 bits per channel; blank outside the active region.
  always_comb begin
    pix_c       = '0;
    h_ext       = 16'(h);
    v_ext       = 16'(v);
    unused_bits = &{1'b0, h_ext[15:9], v_ext[15:9], v_ext[0]};
    if (de_c) begin
      case (mode_cur)
        PAT_BLACK:   pix_c = '0;
        PAT_RED:     pix_c = rgb8_t'(BAR_RED);
        PAT_GREEN:   pix_c = rgb8_t'(BAR_GREEN);
        PAT_BLUE:    pix_c = rgb8_t'(BAR_BLUE);
        PAT_CHECK16: pix_c = (h_ext[4] ~^ v_ext[4]) ? rgb8_t'(BAR_WHITE) : '0;
        PAT_CHECK64: pix_c = (h_ext[6] ~^ v_ext[6]) ? rgb8_t'(BAR_WHITE) : '0;
        PAT_GREY:    pix_c = '{r: h_ext[7:0], g: h_ext[7:0], b: h_ext[7:0]};
        PAT_GRAD:    pix_c = '{r: v_ext[8:1], g: h_ext[8:1], b: h_ext[8:1]};
        PAT_RRAMP:   pix_c = '{r: h_ext[7:0], g: 8'h00, b: 8'h00};
        PAT_GRAMP:   pix_c = '{r: 8'h00, g: h_ext[7:0], b: 8'h00};
        PAT_BRAMP:   pix_c = '{r: 8'h00, g: 8'h00, b: h_ext[7:0]};
        PAT_BARS:    pix_c = bar_rgb(bar_idx);
        default:     pix_c = rgb8_t'(BAR_WHITE);
      endcase
    end
  end

  // Single output stage; every output reflects the same h/v sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r           <= '0;
      g           <= '0;
      b           <= '0;
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      frame_start <= 1'b0;
    end else begin
      r           <= CW'(align8(pix_c.r, CW));
      g           <= CW'(align8(pix_c.g, CW));
      b           <= CW'(align8(pix_c.b, CW));
      de          <= de_c;
      hsync       <= hs_c ? HS_POL : ~HS_POL;
      vsync       <= vs_c ? VS_POL : ~VS_POL;
      frame_start <= sof_c;
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Cycle-accurate scoreboard bench for video_pattern_gen on a small raster,
// with one CW=10 and one CW=6 instance driven from the same inputs.
module tb_video_pattern_gen;

  localparam int HA = 20, HFP = 2, HS = 3, HBP = 3;
  localparam int VA = 6,  VFP = 1, VS = 2, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;

  typedef struct packed {
    logic [29:0] rgb10;
    logic [17:0] rgb6;
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [3:0]  mode;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] mode_sel;
  logic       auto_en;

  logic [9:0] r10, g10, b10;
  logic       de10, hs10, vs10, fs10;
  logic [3:0] mode10;
  logic [5:0] r6, g6, b6;
  logic       de6, hs6, vs6, fs6;
  logic [3:0] mode6;

  exp_t sb[$];
  int   tests;
  int   fails;
  int   cyc;
  int   mh, mv, mfc;
  logic [3:0] mmode;

  video_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .CW(10), .CNT_W(12), .HS_POL(1'b1), .VS_POL(1'b0), .AUTO_FRAMES(2)
  ) dut10 (
    .clk(clk), .rst(rst), .mode_sel(mode_sel), .auto_en(auto_en),
    .r(r10), .g(g10), .b(b10), .de(de10), .hsync(hs10), .vsync(vs10),
    .frame_start(fs10), .mode_cur(mode10)
  );

  video_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .CW(6), .CNT_W(12), .HS_POL(1'b1), .VS_POL(1'b0), .AUTO_FRAMES(2)
  ) dut6 (
    .clk(clk), .rst(rst), .mode_sel(mode_sel), .auto_en(auto_en),
    .r(r6), .g(g6), .b(b6), .de(de6), .hsync(hs6), .vsync(vs6),
    .frame_start(fs6), .mode_cur(mode6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected 8-bit RGB for a counter position and pattern.
  function automatic logic [23:0] exp_rgb8(input int hh, input int vv, input logic [3:0] m);
    logic [7:0] x;
    logic [7:0] hy;
    logic [7:0] vy;
    int idx;
    if (!(hh < HA && vv < VA)) return 24'h000000;
    x  = 8'(hh);
    hy = 8'(hh >> 1);
    vy = 8'(vv >> 1);
    case (m)
      4'd0:  return 24'h000000;
      4'd2:  return 24'hFF0000;
      4'd3:  return 24'h00FF00;
      4'd4:  return 24'h0000FF;
      4'd5:  return (((hh >> 4) & 1) == ((vv >> 4) & 1)) ? 24'hFFFFFF : 24'h000000;
      4'd6:  return (((hh >> 6) & 1) == ((vv >> 6) & 1)) ? 24'hFFFFFF : 24'h000000;
      4'd7:  return {x, x, x};
      4'd8:  return {vy, hy, hy};
      4'd9:  return {x, 16'h0000};
      4'd10: return {8'h00, x, 8'h00};
      4'd11: return {16'h0000, x};
      4'd12: begin
        idx = hh / (HA / 8);
        if (idx > 7) idx = 7;
        case (idx)
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      default: return 24'hFFFFFF;
    endcase
  endfunction

  function automatic logic [9:0] to10(input logic [7:0] x);
    return (x == 8'hFF) ? 10'h3FF : {x, 2'b00};
  endfunction

  function automatic logic [5:0] to6(input logic [7:0] x);
    return x[7:2];
  endfunction

  // One clock: predict from the model, advance it, then compare both DUTs.
  task automatic tick();
    exp_t e;
    logic [23:0] p;
    if (rst) begin
      e = '0;
      e.hs = 1'b0;
      e.vs = 1'b1;
      mh = 0; mv = 0; mfc = 0; mmode = 4'd0;
    end else begin
      p       = exp_rgb8(mh, mv, mmode);
      e.rgb10 = {to10(p[23:16]), to10(p[15:8]), to10(p[7:0])};
      e.rgb6  = {to6(p[23:16]), to6(p[15:8]), to6(p[7:0])};
      e.de    = (mh < HA) && (mv < VA);
      e.hs    = (mh >= HA + HFP) && (mh < HA + HFP + HS);
      e.vs    = !((mv >= VA + VFP) && (mv < VA + VFP + VS));
      e.fs    = (mh == 0) && (mv == 0);
      if (mh == HT - 1 && mv == VT - 1) begin
        if (!auto_en) mmode = mode_sel;
        else if (mfc == 1) begin
          mfc = 0;
          mmode = (mmode >= 4'd12) ? 4'd0 : 4'(mmode + 4'd1);
        end else mfc = mfc + 1;
      end
      if (!auto_en) mfc = 0;
      e.mode = mmode;
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    e = sb.pop_front();
    tests = tests + 1;
    assert ({r10, g10, b10} === e.rgb10) else begin
      fails = fails + 1;
      $error("FAIL rgb10 cyc=%0d obs=%h exp=%h", cyc, {r10, g10, b10}, e.rgb10);
    end
    tests = tests + 1;
    assert ({de10, hs10, vs10, fs10, mode10} === {e.de, e.hs, e.vs, e.fs, e.mode}) else begin
      fails = fails + 1;
      $error("FAIL ctl10 cyc=%0d obs=%b exp=%b", cyc, {de10, hs10, vs10, fs10, mode10},
             {e.de, e.hs, e.vs, e.fs, e.mode});
    end
    tests = tests + 1;
    assert ({r6, g6, b6} === e.rgb6) else begin
      fails = fails + 1;
      $error("FAIL rgb6 cyc=%0d obs=%h exp=%h", cyc, {r6, g6, b6}, e.rgb6);
    end
    tests = tests + 1;
    assert ({de6, hs6, vs6, fs6, mode6} === {e.de, e.hs, e.vs, e.fs, e.mode}) else begin
      fails = fails + 1;
      $error("FAIL ctl6 cyc=%0d obs=%b exp=%b", cyc, {de6, hs6, vs6, fs6, mode6},
             {e.de, e.hs, e.vs, e.fs, e.mode});
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0;
    mh = 0; mv = 0; mfc = 0; mmode = 4'd0;
    rst = 1'b1; mode_sel = 4'd12; auto_en = 1'b0;

    // Reset values, then frame 0 (black) followed by colour bars.
    run(3);
    rst = 1'b0;
    run(2 * HT * VT);

    // Grey ramp requested mid-frame; takes effect at the next frame wrap.
    run(HT * VT / 2);
    mode_sel = 4'd7;
    run(2 * HT * VT);

    // Red then green requested mid-frame.
    mode_sel = 4'd2;
    run(HT * VT);
    mode_sel = 4'd3;
    run(HT * VT + 10);

    // Remaining patterns, including the out-of-range indices.
    for (int m = 0; m < 16; m++) begin
      mode_sel = 4'(m);
      run(HT * VT);
    end

    // Auto-cycle starting from pattern 11, through the 12 -> 0 wrap.
    mode_sel = 4'd11;
    run(HT * VT);
    auto_en = 1'b1;
    run(30 * HT * VT);
    auto_en = 1'b0;
    mode_sel = 4'd9;
    run(HT * VT + 37);

    // Reset pulsed mid-line, then recovery.
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(2 * HT * VT);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
